regfile_mp: RTL and testbench

Parametrised multi-read-port register file, successor to the 8x8 two-read-port file in the CPU datapath.
- Generalised width, depth and read-port count.
- Adds async clear, optional hardwired-zero register 0, and write-to-read bypass.
- Adds a per-register busy scoreboard for multi-cycle producers, and a software-triggered sequential clear engine.
- Sits between decode (read addresses, reservations) and writeback (write port).

---
 rtl/regfile_mp.sv | 127 ++++++++++++
 tb/tb_regfile_mp.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised register file with combinational multi-port reads, write-to-read
// bypass, per-register busy scoreboard and a sequential clear engine.
module regfile_mp #(
    parameter int W        = 8,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WriteEn,
    input  logic [AW-1:0]     Waddr,
    input  logic [W-1:0]      DataIn,
    input  logic [NRD*AW-1:0] Raddr,
    output logic [NRD*W-1:0]  DataOut,
    input  logic              ReserveEn,
    input  logic [AW-1:0]     ReserveAddr,
    output logic [DEPTH-1:0]  Busy,
    input  logic              ClearReq,
    output logic              Ready,
    output logic [W-1:0]      RegLo,
    output logic [W-1:0]      RegHi
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] count;
    logic [W-1:0]  mem [DEPTH];
    logic          write_ok;
    logic          reserve_ok;
    logic          waddr_zero;
    logic          raddr_zero;

    // Register 0 is only special when the hardwired-zero option is enabled.
    assign waddr_zero = (ZERO_REG != 0) && (Waddr == '0);
    assign raddr_zero = (ZERO_REG != 0) && (ReserveAddr == '0);
    assign write_ok   = WriteEn && Ready && !waddr_zero;
    assign reserve_ok = ReserveEn && Ready && !raddr_zero;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (ClearReq) next_state = CLEAR;
            CLEAR: if (count == LAST) next_state = IDLE;
        endcase
    end

    always_comb begin
        Ready = (state == IDLE);
    end

    // Sweep pointer: parked at 0 while idle, so the first CLEAR cycle hits register 0.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (state == IDLE) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[count] <= '0;
        end else if (write_ok) begin
            mem[Waddr] <= DataIn;
        end
    end

    // Reserve is applied after the write so a same-cycle reservation wins.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Busy <= '0;
        end else if (state == CLEAR) begin
            Busy[count] <= 1'b0;
        end else begin
            if (write_ok) begin
                Busy[Waddr] <= 1'b0;
            end
            if (reserve_ok) begin
                Busy[ReserveAddr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [W-1:0]  rd;

        assign ra = Raddr[i*AW +: AW];

        always_comb begin
            rd = mem[ra];
            if ((BYPASS != 0) && WriteEn && Ready && (ra == Waddr)) begin
                rd = DataIn;
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end
        end

        assign DataOut[i*W +: W] = rd;
    end

    assign RegLo = (ZERO_REG != 0) ? '0 : mem[0];
    assign RegHi = mem[DEPTH-1];

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default, no-bypass and wide hardwired-zero instances
// checked against expectations queued at stimulus time.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;

    // Shared stimulus for the two 8x8 instances (bypass on / bypass off).
    logic        we;
    logic [2:0]  waddr;
    logic [7:0]  din;
    logic [5:0]  raddr;
    logic        re_en;
    logic [2:0]  re_addr;
    logic        clr;
    logic [15:0] a_dout, b_dout;
    logic [7:0]  a_busy, b_busy;
    logic        a_ready, b_ready;
    logic [7:0]  a_lo, a_hi, b_lo, b_hi;

    // Wide instance: W=16, DEPTH=16, NRD=4, hardwired zero.
    logic        c_we;
    logic [3:0]  c_waddr;
    logic [15:0] c_din;
    logic [15:0] c_raddr;
    logic        c_re_en;
    logic [3:0]  c_re_addr;
    logic        c_clr;
    logic [63:0] c_dout;
    logic [15:0] c_busy;
    logic        c_ready;
    logic [15:0] c_lo, c_hi;

    logic [63:0] exp_q[$];
    logic [63:0] exp;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    regfile_mp #(.W(8), .DEPTH(8), .NRD(2), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .Clk(clk), .Reset(rst_n), .WriteEn(we), .Waddr(waddr), .DataIn(din),
        .Raddr(raddr), .DataOut(a_dout), .ReserveEn(re_en), .ReserveAddr(re_addr),
        .Busy(a_busy), .ClearReq(clr), .Ready(a_ready), .RegLo(a_lo), .RegHi(a_hi)
    );

    regfile_mp #(.W(8), .DEPTH(8), .NRD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .Clk(clk), .Reset(rst_n), .WriteEn(we), .Waddr(waddr), .DataIn(din),
        .Raddr(raddr), .DataOut(b_dout), .ReserveEn(re_en), .ReserveAddr(re_addr),
        .Busy(b_busy), .ClearReq(clr), .Ready(b_ready), .RegLo(b_lo), .RegHi(b_hi)
    );

    regfile_mp #(.W(16), .DEPTH(16), .NRD(4), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .Clk(clk), .Reset(rst_n), .WriteEn(c_we), .Waddr(c_waddr), .DataIn(c_din),
        .Raddr(c_raddr), .DataOut(c_dout), .ReserveEn(c_re_en), .ReserveAddr(c_re_addr),
        .Busy(c_busy), .ClearReq(c_clr), .Ready(c_ready), .RegLo(c_lo), .RegHi(c_hi)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; waddr = 0; din = 0; raddr = 0; re_en = 0; re_addr = 0; clr = 0;
        c_we = 0; c_waddr = 0; c_din = 0; c_raddr = 0; c_re_en = 0; c_re_addr = 0; c_clr = 0;
    endtask

    task automatic write_a(input logic [2:0] a, input logic [7:0] d);
        we = 1; waddr = a; din = d;
        step();
        we = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        exp_q.push_back(64'h0);      // a_dout
        exp_q.push_back(64'h0);      // a_busy
        exp_q.push_back(64'h1);      // a_ready
        exp_q.push_back(64'h0);      // a_hi
        exp_q.push_back(64'h1);      // c_ready
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, a_dout} !== exp) begin n_bad++; $display("FAIL reset_dout got %h want %h", a_dout, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_busy} !== exp) begin n_bad++; $display("FAIL reset_busy got %h want %h", a_busy, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({63'h0, a_ready} !== exp) begin n_bad++; $display("FAIL reset_ready got %h want %h", a_ready, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_hi} !== exp) begin n_bad++; $display("FAIL reset_reghi got %h want %h", a_hi, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({63'h0, c_ready} !== exp) begin n_bad++; $display("FAIL reset_c_ready got %h want %h", c_ready, exp); end
        rst_n = 1;
        step();
    endtask

    task automatic test_defaults();
        write_a(3'd3, 8'hA5);
        write_a(3'd7, 8'h3C);
        raddr = {3'd7, 3'd3};
        exp_q.push_back({48'h0, 8'h3C, 8'hA5});
        exp_q.push_back(64'h3C);
        #1;
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, a_dout} !== exp) begin n_bad++; $display("FAIL defaults_read got %h want %h", a_dout, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_hi} !== exp) begin n_bad++; $display("FAIL defaults_reghi got %h want %h", a_hi, exp); end
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 7) continue;
            raddr = {3'(i), 3'(i)};
            exp_q.push_back(64'h0);
            #1;
            exp = exp_q.pop_front(); n_vec++;
            if ({48'h0, a_dout} !== exp) begin n_bad++; $display("FAIL unwritten_r%0d got %h want %h", i, a_dout, exp); end
        end
    endtask

    task automatic test_bypass();
        we = 1; waddr = 3'd5; din = 8'h11; raddr = {3'd3, 3'd5};
        exp_q.push_back({48'h0, 8'hA5, 8'h11});   // bypass instance sees DataIn
        exp_q.push_back({48'h0, 8'hA5, 8'h00});   // non-bypass instance sees old value
        #1;
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, a_dout} !== exp) begin n_bad++; $display("FAIL bypass_on got %h want %h", a_dout, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, b_dout} !== exp) begin n_bad++; $display("FAIL bypass_off_same got %h want %h", b_dout, exp); end
        step();
        we = 0;
        exp_q.push_back({48'h0, 8'hA5, 8'h11});
        #1;
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, b_dout} !== exp) begin n_bad++; $display("FAIL bypass_off_next got %h want %h", b_dout, exp); end
    endtask

    task automatic test_random();
        logic [7:0] m [8];
        logic [2:0] r0, r1;
        logic [7:0] e0, e1;
        for (int i = 0; i < 8; i++) begin
            m[i] = 8'($urandom_range(0, 255));
            write_a(3'(i), m[i]);
        end
        for (int k = 0; k < 24; k++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 3'($urandom_range(0, 7));
            din = 8'($urandom_range(0, 255));
            r0 = 3'($urandom_range(0, 7));
            r1 = (k % 4 == 0) ? waddr : 3'($urandom_range(0, 7));
            raddr = {r1, r0};
            e0 = (we && r0 == waddr) ? din : m[r0];
            e1 = (we && r1 == waddr) ? din : m[r1];
            exp_q.push_back({48'h0, e1, e0});
            #1;
            exp = exp_q.pop_front(); n_vec++;
            if ({48'h0, a_dout} !== exp) begin n_bad++; $display("FAIL random_read_%0d got %h want %h", k, a_dout, exp); end
            if (we) m[waddr] = din;
            step();
        end
        we = 0;
    endtask

    task automatic test_scoreboard();
        re_en = 1; re_addr = 3'd2;
        step();
        re_en = 0;
        exp_q.push_back(64'h04);
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_busy} !== exp) begin n_bad++; $display("FAIL reserve_r2 got %h want %h", a_busy, exp); end
        re_en = 1;
        step();
        re_en = 0;
        exp_q.push_back(64'h04);
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_busy} !== exp) begin n_bad++; $display("FAIL rereserve_r2 got %h want %h", a_busy, exp); end
        write_a(3'd2, 8'h77);
        exp_q.push_back(64'h00);
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_busy} !== exp) begin n_bad++; $display("FAIL write_frees_r2 got %h want %h", a_busy, exp); end
        we = 1; waddr = 3'd2; din = 8'h99; re_en = 1; re_addr = 3'd2;
        step();
        we = 0; re_en = 0; raddr = {3'd0, 3'd2};
        exp_q.push_back(64'h04);
        exp_q.push_back(64'h99);
        #1;
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_busy} !== exp) begin n_bad++; $display("FAIL write_reserve_busy got %h want %h", a_busy, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_dout[7:0]} !== exp) begin n_bad++; $display("FAIL write_reserve_data got %h want %h", a_dout[7:0], exp); end
        write_a(3'd2, 8'h99);
    endtask

    task automatic test_clear();
        int n_low;
        for (int i = 0; i < 8; i++) write_a(3'(i), 8'hFF);
        re_en = 1;
        for (int i = 0; i < 8; i++) begin
            re_addr = 3'(i);
            step();
        end
        re_en = 0;
        exp_q.push_back(64'hFF);
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_busy} !== exp) begin n_bad++; $display("FAIL clear_busy_before got %h want %h", a_busy, exp); end
        clr = 1;
        step();
        clr = 0;
        n_low = 0;
        for (int k = 0; k < 20; k++) begin
            if (a_ready !== 1'b0) break;
            n_low++;
            we = 0; re_en = 0;
            if (k == 4) begin
                // Registers 0..3 are swept by now; 7 is not yet.
                we = 1; waddr = 3'd1; din = 8'h55; re_en = 1; re_addr = 3'd1; clr = 1;
                raddr = {3'd7, 3'd1};
                exp_q.push_back({48'h0, 8'hFF, 8'h00});
                #1;
                exp = exp_q.pop_front(); n_vec++;
                if ({48'h0, a_dout} !== exp) begin n_bad++; $display("FAIL clear_partial_read got %h want %h", a_dout, exp); end
            end
            step();
            clr = 0;
        end
        we = 0; re_en = 0;
        exp_q.push_back(64'd8);
        exp_q.push_back(64'h00);
        exp_q.push_back(64'h1);
        exp = exp_q.pop_front(); n_vec++;
        if (64'(n_low) !== exp) begin n_bad++; $display("FAIL clear_ready_low_cycles got %0d want %0d", n_low, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_busy} !== exp) begin n_bad++; $display("FAIL clear_busy_after got %h want %h", a_busy, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({63'h0, a_ready} !== exp) begin n_bad++; $display("FAIL clear_ready_after got %h want %h", a_ready, exp); end
        for (int i = 0; i < 8; i++) begin
            raddr = {3'(i), 3'(i)};
            exp_q.push_back(64'h0);
            #1;
            exp = exp_q.pop_front(); n_vec++;
            if ({48'h0, a_dout} !== exp) begin n_bad++; $display("FAIL clear_r%0d got %h want %h", i, a_dout, exp); end
        end
    endtask

    task automatic test_zero_reg();
        c_we = 1; c_waddr = 4'd0; c_din = 16'hBEEF; c_raddr = 16'h0000;
        exp_q.push_back(64'h0);
        #1;
        exp = exp_q.pop_front(); n_vec++;
        if (c_dout !== exp) begin n_bad++; $display("FAIL zero_same_cycle got %h want %h", c_dout, exp); end
        step();
        c_we = 0;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp = exp_q.pop_front(); n_vec++;
        if (c_dout !== exp) begin n_bad++; $display("FAIL zero_after_write got %h want %h", c_dout, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, c_lo} !== exp) begin n_bad++; $display("FAIL zero_reglo got %h want %h", c_lo, exp); end
        c_re_en = 1; c_re_addr = 4'd0;
        step();
        c_re_addr = 4'd15;
        step();
        c_re_en = 0;
        exp_q.push_back(64'h8000);
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, c_busy} !== exp) begin n_bad++; $display("FAIL zero_reserve got %h want %h", c_busy, exp); end
        c_we = 1; c_waddr = 4'd15; c_din = 16'h1234;
        step();
        c_waddr = 4'd1; c_din = 16'h0ABC; c_raddr = {4'd1, 4'd15, 4'd0, 4'd1};
        exp_q.push_back({16'h0ABC, 16'h1234, 16'h0000, 16'h0ABC});
        exp_q.push_back(64'h1234);
        exp_q.push_back(64'h0000);
        #1;
        exp = exp_q.pop_front(); n_vec++;
        if (c_dout !== exp) begin n_bad++; $display("FAIL wide_ports got %h want %h", c_dout, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, c_hi} !== exp) begin n_bad++; $display("FAIL wide_reghi got %h want %h", c_hi, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, c_busy} !== exp) begin n_bad++; $display("FAIL wide_write_frees got %h want %h", c_busy, exp); end
        step();
        c_we = 0;
    endtask

    task automatic test_async_reset();
        write_a(3'd0, 8'h12);
        write_a(3'd7, 8'h3C);
        re_en = 1; re_addr = 3'd4;
        step();
        re_en = 0;
        clr = 1;
        step();
        clr = 0;
        step();
        step();
        #2;
        rst_n = 0;
        raddr = {3'd7, 3'd4};
        #1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h0);
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_hi} !== exp) begin n_bad++; $display("FAIL areset_reghi got %h want %h", a_hi, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, a_dout} !== exp) begin n_bad++; $display("FAIL areset_dout got %h want %h", a_dout, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({56'h0, a_busy} !== exp) begin n_bad++; $display("FAIL areset_busy got %h want %h", a_busy, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({63'h0, a_ready} !== exp) begin n_bad++; $display("FAIL areset_ready got %h want %h", a_ready, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, c_hi} !== exp) begin n_bad++; $display("FAIL areset_c_reghi got %h want %h", c_hi, exp); end
        step();
        rst_n = 1;
        step();
        write_a(3'd6, 8'h6A);
        raddr = {3'd6, 3'd6};
        exp_q.push_back({48'h0, 8'h6A, 8'h6A});
        exp_q.push_back(64'h1);
        #1;
        exp = exp_q.pop_front(); n_vec++;
        if ({48'h0, a_dout} !== exp) begin n_bad++; $display("FAIL areset_first_write got %h want %h", a_dout, exp); end
        exp = exp_q.pop_front(); n_vec++;
        if ({63'h0, a_ready} !== exp) begin n_bad++; $display("FAIL areset_ready_after got %h want %h", a_ready, exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_defaults();
        test_bypass();
        test_random();
        test_scoreboard();
        test_clear();
        test_zero_reg();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
